// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: FSM state encoding,
// operating-mode constants, the arctangent table generator and the gain
// compensation constant. The optional gain stage is enabled with the
// CORDIC_GAIN_COMP_EN macro (see cordic_iter_engine.sv).
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAIN = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam real CORDIC_PI       = 3.14159265358979323846;
  localparam real CORDIC_GAIN_INV = 0.607252935;

  // Angle scale: 2^(width-1) represents pi, so atan_0 = pi/4 = 2^(width-3).
  function automatic int cordic_atan(input int i, input int width);
    real a;
    a = $atan(2.0 ** (-i)) / CORDIC_PI * (2.0 ** (width - 1));
    return $rtoi(a + 0.5);
  endfunction

  // 1/K in the same Q(width-1) fixed-point scale as the data path.
  function automatic int cordic_gain(input int width);
    real g;
    g = CORDIC_GAIN_INV * (2.0 ** (width - 1));
    return $rtoi(g + 0.5);
  endfunction

endpackage

// File: rtl/cordic_iter_engine_if.sv
// Handshake and operand/result bundle for cordic_iter_engine.
// master drives the request side, slave is the engine itself.
interface cordic_iter_engine_if #(
  parameter int WIDTH = 19
);

  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;

  modport master (
    output start, mode, x_in, y_in, z_in,
    input  busy, done, x_out, y_out, z_out
  );

  modport slave (
    input  start, mode, x_in, y_in, z_in,
    output busy, done, x_out, y_out, z_out
  );

endinterface

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation: arithmetic shifts by the
// iteration index, conditional add/subtract on x/y and the angle update.
// Direction d is chosen from z (rotation) or from y (vectoring).
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                    mode,
  input  logic [SHW-1:0]          shift,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  input  logic signed [WIDTH-1:0] atan_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;
  logic                    d_pos;

  // Pick the rotation direction and apply one shift-add step (wraps mod 2^WIDTH).
  always_comb begin
    x_sh = x_i >>> shift;
    y_sh = y_i >>> shift;
    if (mode == MODE_VEC) begin
      d_pos = y_i[WIDTH-1];
    end else begin
      d_pos = ~z_i[WIDTH-1];
    end
    if (d_pos) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock in RUN, results
// held in the working registers which double as the outputs.
// Optional gain compensation stage: define CORDIC_GAIN_COMP_EN to insert a
// GAIN state that scales x and y by 1/K after the last micro-rotation.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int ITERS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cordic_iter_engine_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int TAB_N = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(ITERS - 1);

  cordic_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;

  logic signed [WIDTH-1:0] x_rot, y_rot, z_rot;
  logic signed [WIDTH-1:0] atan_tab [TAB_N];

  // Table is sized to the full counter range so any counter value indexes it.
  for (genvar g = 0; g < TAB_N; g++) begin : g_atan
    localparam int ATAN_G = cordic_atan(g, WIDTH);
    assign atan_tab[g] = WIDTH'(ATAN_G);
  end

  cordic_micro_rotation #(
    .WIDTH (WIDTH),
    .SHW   (CNT_W)
  ) u_rot (
    .mode   (mode_q),
    .shift  (cnt_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .atan_i (atan_tab[cnt_q]),
    .x_o    (x_rot),
    .y_o    (y_rot),
    .z_o    (z_rot)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam int GAIN_I = cordic_gain(WIDTH);
  localparam logic [WIDTH-1:0] GAIN_K = WIDTH'(GAIN_I);

  logic [2*WIDTH-1:0] x_prod;
  logic [2*WIDTH-1:0] y_prod;

  // Sign-extended operands so the low 2*WIDTH product bits equal the signed product.
  always_comb begin
    x_prod = {{WIDTH{x_q[WIDTH-1]}}, x_q} * {{WIDTH{1'b0}}, GAIN_K};
    y_prod = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{1'b0}}, GAIN_K};
  end
`endif

  // Next-state, counter and working-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          z_d     = bus.z_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_GAIN;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
        x_d     = x_prod[2*WIDTH-2:WIDTH-1];
        y_d     = y_prod[2*WIDTH-2:WIDTH-1];
        state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and working registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_ROT;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  // Status decode and result outputs straight from the registers.
  always_comb begin
    bus.busy  = (state_q == ST_RUN) || (state_q == ST_GAIN);
    bus.done  = (state_q == ST_DONE);
    bus.x_out = x_q;
    bus.y_out = y_q;
    bus.z_out = z_q;
  end

endmodule
